// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared definitions for the EX-stage data SRAM to AXI bridge:
// FSM state encodings, AXI transfer-size codes and response helpers.
package data_sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    BR_IDLE  = 3'd0,
    BR_RD_A  = 3'd1,
    BR_RD_D  = 3'd2,
    BR_WR_AW = 3'd3,
    BR_WR_B  = 3'd4,
    BR_DONE  = 3'd5
  } br_state_e;

  localparam logic [2:0] SIZE_B = 3'b000;
  localparam logic [2:0] SIZE_H = 3'b001;
  localparam logic [2:0] SIZE_W = 3'b010;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Any response other than OKAY is reported to the core as a bus error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/data_sram_axi_bridge_wen_to_axsize.sv
// Maps SRAM byte write enables onto an AXI transfer size.
// A single byte lane is a byte access, an aligned half-word lane pair is a
// half-word access, and every other pattern is sent as a full word with
// strobes doing the masking. Shared with the instruction-side bridge.
module data_sram_axi_bridge_wen_to_axsize
  import data_sram_axi_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic [2:0] axsize
);

  // Pure decode of the lane pattern; anything unrecognised falls back to word.
  always_comb begin
    axsize = SIZE_W;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: axsize = SIZE_B;
      4'b0011, 4'b1100:                   axsize = SIZE_H;
      default:                            axsize = SIZE_W;
    endcase
  end

endmodule

// File: rtl/data_sram_axi_bridge.sv
// Responder end of the EX-stage data SRAM interface. Each single-word SRAM
// request becomes one AXI4-lite-style read or write; the pipeline is stalled
// until the transaction finishes, and read data is held for the MEM stage.
// Only one request is ever outstanding. Only DATA_W = 32 is supported.
module data_sram_axi_bridge
  import data_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq_for_bus,
  output logic              bus_err,

  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,

  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,

  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awid,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,

  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,

  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  br_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wen_q;
  logic              aw_done;
  logic              w_done;

  logic              aw_hs;
  logic              w_hs;
  logic              aw_ok;
  logic              w_ok;

  // AW and W are independent channels; a handshake this cycle counts the
  // same as one recorded earlier when deciding whether both have finished.
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done | w_hs;

  // AXI-side address/data come from the latched request only, so they stay
  // stable while valid is high no matter what EX does to its inputs.
  assign araddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign arid   = AXI_ID;
  assign arsize = SIZE_W;
  assign awaddr = addr_q;
  assign awid   = AXI_ID;
  assign wdata  = wdata_q;
  assign wstrb  = wen_q;

  data_sram_axi_bridge_wen_to_axsize u_wen_to_axsize (
    .wen    (wen_q),
    .axsize (awsize)
  );

  // Stall from the very cycle a request appears until the transaction is
  // finished; DONE is the single released cycle in which the pipeline moves.
  always_comb begin
    stallreq_for_bus = 1'b1;
    case (state)
      BR_IDLE:  stallreq_for_bus = data_sram_en;
      BR_RD_A:  stallreq_for_bus = 1'b1;
      BR_RD_D:  stallreq_for_bus = 1'b1;
      BR_WR_AW: stallreq_for_bus = 1'b1;
      BR_WR_B:  stallreq_for_bus = 1'b1;
      BR_DONE:  stallreq_for_bus = 1'b0;
      default:  stallreq_for_bus = 1'b0;
    endcase
  end

  // Transaction FSM with registered valid/ready outputs, captured read data
  // and a bus_err flag that is only ever high during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= BR_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wen_q           <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      awvalid         <= 1'b0;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
      data_sram_rdata <= '0;
      bus_err         <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        BR_IDLE: begin
          if (data_sram_en) begin
            addr_q <= data_sram_addr;
            if (data_sram_wen == 4'b0000) begin
              arvalid <= 1'b1;
              state   <= BR_RD_A;
            end else begin
              wdata_q <= data_sram_wdata;
              wen_q   <= data_sram_wen;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= BR_WR_AW;
            end
          end
        end

        BR_RD_A: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= BR_RD_D;
          end
        end

        BR_RD_D: begin
          if (rvalid) begin
            rready          <= 1'b0;
            data_sram_rdata <= rdata;
            bus_err         <= resp_is_err(rresp);
            state           <= BR_DONE;
          end
        end

        BR_WR_AW: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= BR_WR_B;
          end
        end

        BR_WR_B: begin
          if (bvalid) begin
            bready  <= 1'b0;
            bus_err <= resp_is_err(bresp);
            state   <= BR_DONE;
          end
        end

        BR_DONE: begin
          state <= BR_IDLE;
        end

        default: begin
          state <= BR_IDLE;
        end
      endcase
    end
  end

endmodule
